// File: rtl/seg7_pkg.sv
// Shared types and the hex font for the 7-segment scan scheduler.
// Font bits are ordered {a,b,c,d,e,f,g}; the dot is appended by the user of the font.
package seg7_pkg;

    typedef logic [7:0] seg7_t;

    localparam logic [6:0] SEG7_FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg7_font(input logic [3:0] nib);
        return SEG7_FONT[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Dwell counter and round-robin digit index for the scan scheduler.
// slot_tick marks the last cycle of a slot; frame_tick marks the last cycle of a frame.
module seg7_scan_timer #(
    parameter  int period  = 4,
    parameter  int w_digit = 4,
    localparam int CNT_W   = (period > 1) ? $clog2(period) : 1,
    localparam int IDX_W   = (w_digit > 1) ? $clog2(w_digit) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             slot_tick,
    output logic             frame_tick
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        slot_tick  = (cnt == CNT_W'(period - 1));
        frame_tick = slot_tick && (idx == IDX_W'(w_digit - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_tick) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(w_digit - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Time-multiplexed 7-segment scanner with a one-deep pending slot committed at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int clk_mhz  = 50,
    parameter int w_digit  = 6,
    parameter int digit_hz = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*w_digit-1:0] in_number,
    input  logic [w_digit-1:0]   in_dots,
    output seg7_t                abcdefgh,
    output logic [w_digit-1:0]   digit
);

    localparam int P     = clk_mhz * 1_000_000 / digit_hz;
    localparam int IDX_W = (w_digit > 1) ? $clog2(w_digit) : 1;

    if (P < 2) begin : g_bad_period
        $error("seg7_scan_scheduler: dwell period must be at least 2 cycles");
    end

    logic [IDX_W-1:0]     idx;
    logic                 slot_tick;
    logic                 frame_tick;

    logic [4*w_digit-1:0] pend_number;
    logic [w_digit-1:0]   pend_dots;
    logic                 pend_full;
    logic [4*w_digit-1:0] disp_number;
    logic [w_digit-1:0]   disp_dots;

    logic                 accept;
    logic                 commit;
    logic [w_digit-1:0]   lit;
    logic [w_digit-1:0]   digit_nx;
    seg7_t                seg_nx;

    seg7_scan_timer #(
        .period  (P),
        .w_digit (w_digit)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .slot_tick  (slot_tick),
        .frame_tick (frame_tick)
    );

    // Handshake: valid/ready transfer when both high. A full pending slot
    // holds ready low until the frame boundary moves it into the display.
    assign in_ready = !pend_full;
    assign accept   = in_valid && in_ready;
    assign commit   = slot_tick && frame_tick && pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_number <= '0;
            pend_dots   <= '0;
            pend_full   <= 1'b0;
            disp_number <= '0;
            disp_dots   <= '0;
        end else if (commit) begin
            disp_number <= pend_number;
            disp_dots   <= pend_dots;
            pend_full   <= 1'b0;
        end else if (accept) begin
            pend_number <= in_number;
            pend_dots   <= in_dots;
            pend_full   <= 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit goes dark only when it and everything above it is an undotted zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lit        = '1;
        for (int i = w_digit - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_number[4*i +: 4] == 4'h0) && !disp_dots[i];
            lit[i]     = !zero_above;
        end
    end
`else
    assign lit = '1;
`endif

    always_comb begin
        digit_nx = '0;
        seg_nx   = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (idx == IDX_W'(i) && lit[i]) begin
                digit_nx[i] = 1'b1;
                seg_nx      = {seg7_font(disp_number[4*i +: 4]), disp_dots[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit    <= '0;
            abcdefgh <= '0;
        end else begin
            digit    <= digit_nx;
            abcdefgh <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Self-checking bench for seg7_scan_scheduler with P=4 and four digits.
// The reference model derives slot, frame boundary and display contents from the cycle count.
module tb_seg7_scan_scheduler;

    localparam int CLK_MHZ  = 1;
    localparam int DIGIT_HZ = 250000;
    localparam int W        = 4;
    localparam int P        = 4;
    localparam int FRAME    = P * W;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_number;
    logic [3:0]  in_dots;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_scheduler #(
        .clk_mhz  (CLK_MHZ),
        .w_digit  (W),
        .digit_hz (DIGIT_HZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_number (in_number),
        .in_dots   (in_dots),
        .abcdefgh  (abcdefgh),
        .digit     (digit)
    );

    function automatic logic [6:0] ref_font(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Reference model: pending values live in exp_q, display value in m_disp_*.
    logic [19:0] exp_q[$];
    logic [15:0] m_disp_num;
    logic [3:0]  m_disp_dots;
    int          m_t;
    int          m_acc = 0;
    logic [3:0]  exp_digit;
    logic [7:0]  exp_seg;
    logic        exp_ready;

    always @(posedge clk) begin : model
        int pos;
        int slot;
        bit blank;
        if (rst) begin
            m_t = 0;
            exp_q.delete();
            m_disp_num  = '0;
            m_disp_dots = '0;
            exp_digit   = '0;
            exp_seg     = '0;
            exp_ready   = 1'b1;
        end else begin
            pos  = m_t;
            m_t  = m_t + 1;
            slot = (pos / P) % W;
            blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            blank = (slot > 0) && ((m_disp_num >> (4 * slot)) == 16'h0)
                    && ((m_disp_dots >> slot) == 4'h0);
`endif
            if (blank) begin
                exp_digit = '0;
                exp_seg   = '0;
            end else begin
                exp_digit = 4'(1 << slot);
                exp_seg   = {ref_font(m_disp_num[4*slot +: 4]), m_disp_dots[slot]};
            end
            if ((pos % FRAME) == FRAME - 1 && exp_q.size() > 0)
                {m_disp_num, m_disp_dots} = exp_q.pop_front();
            if (in_valid && exp_ready) begin
                exp_q.push_back({in_number, in_dots});
                m_acc = m_acc + 1;
            end
            exp_ready = (exp_q.size() == 0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_frame_pos(input int target);
        for (int k = 0; k < FRAME && (m_t % FRAME) != target; k++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (abcdefgh !== 8'h00 || digit !== 4'b0000 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold seg=%h/00 digit=%b/0000 rdy=%b/1", abcdefgh, digit, in_ready);
            end
        end
        rst = 1'b0;
        cycle();
        n_checks++;
        if (digit !== 4'b0001 || abcdefgh !== 8'hFC || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release seg=%h/FC digit=%b/0001 rdy=%b/1", abcdefgh, digit, in_ready);
        end
    endtask

    task automatic test_scan();
        for (int c = 0; c < 2 * FRAME; c++) begin
            cycle();
            n_checks++;
            if (digit !== exp_digit || abcdefgh !== 8'hFC || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL scan t=%0d digit=%b/%b seg=%h/FC rdy=%b/1", m_t, digit, exp_digit, abcdefgh, in_ready);
            end
        end
    endtask

    task automatic test_handshake();
        bit seen = 1'b0;
        wait_frame_pos($urandom_range(2, 10));
        in_valid = 1'b1; in_number = 16'h1234; in_dots = 4'b0001;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_ready_fall rdy=%b/0", in_ready);
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            cycle();
            n_checks++;
            if (digit !== exp_digit || abcdefgh !== exp_seg || in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL handshake t=%0d digit=%b/%b seg=%h/%h rdy=%b/%b",
                         m_t, digit, exp_digit, abcdefgh, exp_seg, in_ready, exp_ready);
            end
            if (digit === 4'b0001 && abcdefgh === 8'b0110011_1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL hs_digit0 seen=%b/1", seen);
        end
    endtask

    task automatic test_back_to_back();
        int acc0 = m_acc;
        int t1 = -1;
        int t2 = -1;
        wait_frame_pos(3);
        in_valid = 1'b1; in_number = 16'h5678; in_dots = 4'b0000;
        for (int c = 0; c < 4 * FRAME; c++) begin
            cycle();
            if (m_acc == acc0 + 1) begin
                in_number = 16'hABCD; in_dots = 4'b0001;
            end else if (m_acc >= acc0 + 2) begin
                in_valid = 1'b0;
            end
            n_checks++;
            if (digit !== exp_digit || abcdefgh !== exp_seg || in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL back_to_back t=%0d digit=%b/%b seg=%h/%h rdy=%b/%b",
                         m_t, digit, exp_digit, abcdefgh, exp_seg, in_ready, exp_ready);
            end
            if (t1 < 0 && digit === 4'b0001 && abcdefgh === 8'hFE) t1 = c;
            if (t2 < 0 && digit === 4'b0001 && abcdefgh === 8'h7B) t2 = c;
        end
        in_valid = 1'b0;
        n_checks++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) != FRAME) begin
            n_fail++;
            $display("FAIL b2b_gap gap=%0d/%0d t1=%0d t2=%0d", t2 - t1, FRAME, t1, t2);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2 * FRAME && !exp_ready; k++) cycle();
        wait_frame_pos(1);
        in_valid = 1'b1; in_number = 16'h9999; in_dots = 4'b1111;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < FRAME && exp_digit !== 4'b0100; k++) cycle();
        n_checks++;
        if (digit !== 4'b0100 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_setup digit=%b/0100 rdy=%b/0", digit, in_ready);
        end
        rst = 1'b1;
        cycle();
        n_checks++;
        if (abcdefgh !== 8'h00 || digit !== 4'b0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_blank seg=%h/00 digit=%b/0000 rdy=%b/1", abcdefgh, digit, in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            cycle();
            n_checks++;
            if (digit !== exp_digit || abcdefgh !== 8'hFC || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_after t=%0d digit=%b/%b seg=%h/FC rdy=%b/1",
                         m_t, digit, exp_digit, abcdefgh, in_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_number = 16'($urandom);
            in_dots   = 4'($urandom);
            cycle();
            n_checks++;
            if (digit !== exp_digit || abcdefgh !== exp_seg || in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL random t=%0d digit=%b/%b seg=%h/%h rdy=%b/%b",
                         m_t, digit, exp_digit, abcdefgh, exp_seg, in_ready, exp_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_blanking();
        bit seen_d3;
        bit seen_fd = 1'b0;
        bit exp_d3;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_d3 = 1'b0;
`else
        exp_d3 = 1'b1;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 2 * FRAME && !exp_ready; k++) cycle();
            in_valid = 1'b1; in_number = 16'h0050; in_dots = (pass == 0) ? 4'b0000 : 4'b1000;
            cycle();
            in_valid = 1'b0;
            for (int k = 0; k < 2 * FRAME && !exp_ready; k++) cycle();
            seen_d3 = 1'b0;
            for (int c = 0; c < 2 * FRAME; c++) begin
                cycle();
                n_checks++;
                if (digit !== exp_digit || abcdefgh !== exp_seg || in_ready !== exp_ready) begin
                    n_fail++;
                    $display("FAIL blank%0d t=%0d digit=%b/%b seg=%h/%h rdy=%b/%b",
                             pass, m_t, digit, exp_digit, abcdefgh, exp_seg, in_ready, exp_ready);
                end
                if (digit === 4'b1000) seen_d3 = 1'b1;
                if (pass == 1 && digit === 4'b1000 && abcdefgh === 8'hFD) seen_fd = 1'b1;
            end
            if (pass == 0) begin
                n_checks++;
                if (seen_d3 !== exp_d3) begin
                    n_fail++;
                    $display("FAIL blank_lead_zero d3_lit=%b/%b", seen_d3, exp_d3);
                end
            end
        end
        n_checks++;
        if (!seen_fd) begin
            n_fail++;
            $display("FAIL blank_dot_keeps d3_fd=%b/1", seen_fd);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_number = '0;
        in_dots   = '0;
        test_reset();
        test_scan();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_blanking();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
